// File: rtl/writeback_unit_pkg.sv
// Shared constants for write-back: register select encoding.
package writeback_unit_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        REG_A    = 2'd0,
        REG_B    = 2'd1,
        REG_C    = 2'd2,
        REG_NONE = 2'd3
    } reg_sel_t;

endpackage

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: DEPTH x (dest + data) circular buffer. Besides the head it
// exposes every entry in age order (index 0 = oldest) for forward search.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int WORD_SIZE = 19,
    parameter int DEPTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic [SEL_W-1:0]                     push_dest,
    input  logic [WORD_SIZE-1:0]                 push_data,
    input  logic                                 pop,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic [DEPTH-1:0]                     age_valid,
    output logic [DEPTH-1:0][SEL_W-1:0]          age_dest,
    output logic [DEPTH-1:0][WORD_SIZE-1:0]      age_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]                   rd_ptr, wr_ptr;
    logic [DEPTH-1:0][SEL_W-1:0]     mem_dest;
    logic [DEPTH-1:0][WORD_SIZE-1:0] mem_data;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            mem_dest <= '0;
            mem_data <= '0;
        end else begin
            if (push) begin
                mem_dest[wr_ptr] <= push_dest;
                mem_data[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Age-ordered view of the buffer starting at the read pointer.
    always_comb begin
        age_valid = '0;
        age_dest  = '0;
        age_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_valid[i] = (CW'(i) < count);
            age_dest[i]  = mem_dest[PW'(rd_ptr + PW'(i))];
            age_data[i]  = mem_data[PW'(rd_ptr + PW'(i))];
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU / memory results into an in-order FIFO and
// drains one entry per cycle as a registered LOAD strobe plus data.
// Optional feature macro: WB_FWD_EN adds a combinational forwarding query port.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int WORD_SIZE = 19,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  reg_sel_t             alu_dest,
    input  logic [WORD_SIZE-1:0] alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  reg_sel_t             mem_dest,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 stall,
    output logic                 load_a,
    output logic                 load_b,
    output logic                 load_c,
    output logic [WORD_SIZE-1:0] wb_data,
`ifdef WB_FWD_EN
    input  reg_sel_t             fwd_sel,
    output logic                 fwd_hit,
    output logic [WORD_SIZE-1:0] fwd_data,
`endif
    output logic                 pending
);

    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0]                   count;
    logic [DEPTH-1:0]                age_valid;
    logic [DEPTH-1:0][SEL_W-1:0]     age_dest;
    logic [DEPTH-1:0][WORD_SIZE-1:0] age_data;
    logic                            not_full, mem_push, alu_push, push, pop;
    logic [SEL_W-1:0]                push_dest;
    logic [WORD_SIZE-1:0]            push_data;
    reg_sel_t                        head_dest;

    // Ready depends only on occupancy and memory request, never on the same-cycle pop.
    always_comb begin
        not_full  = (count != CW'(DEPTH));
        mem_ready = not_full;
        alu_ready = not_full && !mem_valid;
        mem_push  = mem_valid && mem_ready;
        alu_push  = alu_valid && alu_ready;
        push      = mem_push || alu_push;
        push_dest = mem_push ? mem_dest : alu_dest;
        push_data = mem_push ? mem_data : alu_data;
        pop       = !stall && (count != '0);
        pending   = (count != '0);
        head_dest = reg_sel_t'(age_dest[0]);
    end

    wb_fifo #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_dest (push_dest),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .age_valid (age_valid),
        .age_dest  (age_dest),
        .age_data  (age_data)
    );

    // Output stage: one-cycle strobe for the popped entry; REG_NONE pops silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_a  <= 1'b0;
            load_b  <= 1'b0;
            load_c  <= 1'b0;
            wb_data <= '0;
        end else begin
            load_a <= pop && (head_dest == REG_A);
            load_b <= pop && (head_dest == REG_B);
            load_c <= pop && (head_dest == REG_C);
            if (pop && (head_dest != REG_NONE))
                wb_data <= age_data[0];
        end
    end

`ifdef WB_FWD_EN
    // Forward search: output stage first, then FIFO oldest to newest so the newest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_sel != REG_NONE) begin
            if ((load_a && fwd_sel == REG_A) || (load_b && fwd_sel == REG_B) ||
                (load_c && fwd_sel == REG_C)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (age_valid[i] && (age_dest[i] == fwd_sel)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = age_data[i];
                end
            end
        end
    end
`else
    // Entries behind the head are only needed by the forward search.
    logic unused_age;
    assign unused_age = ^{age_valid, age_dest, age_data};
`endif

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage that sits directly upstream of registers A–C and drives their load strobes and input data. Results from two producers, the ALU and the memory load path, are accepted over valid/ready handshakes. They are queued in a small in-order FIFO and drained one per cycle as a one-cycle LOAD pulse to the selected register. This decouples result producers from register update timing and lets the pipeline stall write-back without losing results.

## Interface
- WORD_SIZE, 19, data width; matches registers A–C
- DEPTH, 4, FIFO entries; power of two, ≥2
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  reset, asynchronous, active-low
- ALU_VALID  in  1  ALU result offered
- ALU_READY  out  1  ALU result accepted this cycle when high with ALU_VALID
- ALU_DEST  in  2  destination, reg_sel_t
- ALU_DATA  in  WORD_SIZE  ALU result
- MEM_VALID / MEM_READY / MEM_DEST / MEM_DATA  same as ALU_*, memory load path
- STALL  in  1  high: no FIFO pop this cycle
- LOAD_A, LOAD_B, LOAD_C  out  1 each  one-hot (or all-zero) load strobes to registers
- WB_DATA  out  WORD_SIZE  data for the strobed register
- PENDING  out  1  FIFO non-empty
- FWD_SEL  in  2  forwarding query, reg_sel_t (only with WB_FWD_EN)
- FWD_HIT  out  1  a pending value exists for FWD_SEL (only with WB_FWD_EN)
- FWD_DATA  out  WORD_SIZE  newest pending value for FWD_SEL (only with WB_FWD_EN)

## Operation
- reg_sel_t encoding: 0=REG_A, 1=REG_B, 2=REG_C, 3=REG_NONE.
- At most one push per cycle. Memory has priority over the ALU.
- MEM_READY = (count != DEPTH).
- ALU_READY = (count != DEPTH) && !MEM_VALID.
- READY outputs are combinational from count and MEM_VALID; they never depend on the same-cycle pop, so there is no pass-through when full.
- Pop: when !STALL && count>0, the head entry is removed. On the next edge the output stage registers:
  - LOAD_x = 1 for x = head dest
  - WB_DATA = head data
- A REG_NONE entry is popped silently: all LOADs 0, WB_DATA holds its previous value.
- When no pop occurs, all LOAD_* go 0 after the next edge and WB_DATA holds its value.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Order is strictly FIFO across both sources. Two writes to the same register are applied in acceptance order.
- PENDING = (count != 0).

## Timing
- Reset (async assert, sync release): count=0, pointers=0, LOAD_A/B/C=0, WB_DATA=0, PENDING=0. ALU_READY and MEM_READY reflect the empty FIFO immediately (MEM_READY=1).
- Reset asserted mid-operation discards all queued entries. No LOAD pulse is produced for them.
- Latency: a value accepted at edge N is popped at edge N+1 if not stalled. LOAD is high during the cycle after edge N+1. The register captures the value at edge N+2.
- Throughput: one write-back per cycle when unstalled.
- Full (count==DEPTH): both READYs low. Pushing resumes the cycle after a pop.
- STALL held: entries are retained indefinitely. LOADs stay 0 after the first stalled edge.

## Configuration
- WB_FWD_EN defined:
  - FWD_* ports exist. The forwarding logic is combinational.
  - FWD_HIT = 1 if any valid FIFO entry, or the output stage with its LOAD asserted, has dest == FWD_SEL.
  - FWD_DATA comes from the newest matching FIFO entry. The output stage is used only if no FIFO entry matches.
  - FWD_SEL = REG_NONE never hits. On a miss, FWD_DATA = 0.
- WB_FWD_EN undefined: FWD_* ports and the search logic are absent. All other behaviour is identical.

## Structure
- reg_sel_t and the REG_* constants go in the shared constants package, so registers, decode and write-back agree on the encoding.
- One sub-module: wb_fifo, a parameterised DEPTH×(2+WORD_SIZE) circular buffer. It exposes count and per-entry valid/dest/data for the forward search.
- writeback_unit contains the arbitration, output stage and forwarding logic.

## Test plan
- Reset, then ALU pushes REG_B/0x1234A → LOAD_B=1 for exactly one cycle at edge N+1, with WB_DATA=0x1234A; PENDING returns to 0.
- MEM_VALID and ALU_VALID are asserted together for REG_A/0x00001 and REG_C/0x00002 → memory is accepted first and ALU_READY=0. Then LOAD_A→0x00001 is followed by LOAD_C→0x00002.
- STALL=1 with 5 pushes offered → 4 accepted, MEM_READY=0 on the 5th, no LOADs. Release STALL → 4 consecutive LOAD pulses in order, then the 5th is accepted.
- Push REG_NONE/0x7FFFF → popped with no LOAD, and WB_DATA unchanged.
- Assert RST_N=0 with 3 queued entries → no LOAD pulses, all outputs 0, MEM_READY=1.
- WB_FWD_EN with STALL=1: push REG_A/0x00010 then REG_A/0x00020, query FWD_SEL=REG_A → FWD_HIT=1 and FWD_DATA=0x00020. Query REG_B → FWD_HIT=0.
